// File: rtl/img_pkg.sv
// Shared constants, state encoding and luma helper for the image pipeline.
// The MEAN state exists only when GRAY_MEAN_EN is defined.
package img_pkg;

  localparam int PIX_W = 24;
  localparam int R_LSB = 16;
  localparam int G_LSB = 8;
  localparam int B_LSB = 0;

  localparam int COEF_R   = 77;
  localparam int COEF_G   = 150;
  localparam int COEF_B   = 29;
  localparam int LUMA_RND = 128;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WAIT = 3'd2,
    ST_CALC = 3'd3,
    ST_WR   = 3'd4,
    ST_DONE = 3'd5
`ifdef GRAY_MEAN_EN
    ,
    ST_MEAN = 3'd6
`endif
  } state_e;

  // Coefficients sum to 256, so the rounded 16-bit sum never exceeds 65408.
  function automatic logic [7:0] luma(input logic [7:0] r, input logic [7:0] g,
                                      input logic [7:0] b);
    logic [15:0] acc;
    acc = 16'(COEF_R) * 16'(r) + 16'(COEF_G) * 16'(g) + 16'(COEF_B) * 16'(b)
        + 16'(LUMA_RND);
    return 8'(acc >> 8);
  endfunction

endpackage

// File: rtl/gray_mean_div.sv
// Sequential unsigned restoring divider, one quotient bit per cycle.
// Used only by the GRAY_MEAN_EN build of rgb_to_gray.
module gray_mean_div #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient
);

  localparam int CNT_W = $clog2(W + 1);

  logic [W-1:0]     rem_q, rem_d;
  logic [W-1:0]     quo_q, quo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [W:0]       shifted;

  // quo_q doubles as the dividend shift register while the quotient fills in.
  always_comb begin
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    shifted = {rem_q, quo_q[W-1]};
    if (busy_q) begin
      if (shifted >= {1'b0, divisor}) begin
        rem_d = shifted[W-1:0] - divisor;
        quo_d = {quo_q[W-2:0], 1'b1};
      end else begin
        rem_d = shifted[W-1:0];
        quo_d = {quo_q[W-2:0], 1'b0};
      end
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end else if (start) begin
      rem_d  = '0;
      quo_d  = dividend;
      cnt_d  = CNT_W'(W);
      busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign quotient = quo_q;

endmodule

// File: rtl/rgb_to_gray.sv
// Reads RGB888 pixels, writes {Y,Y,Y} back in place; GRAY_MEAN_EN adds a
// frame-mean output (mean_gray) computed after the last write.
//
// state | meaning
// IDLE  | waiting for the first start
// RD    | read strobe for addr_pixel
// WAIT  | waiting for pixel_val, latch RGB
// CALC  | register luma
// WR    | write strobe with {Y,Y,Y}
// MEAN  | dividing the luma sum by the pixel count (GRAY_MEAN_EN only)
// DONE  | frame complete, waiting for the next start
module rgb_to_gray
  import img_pkg::*;
#(
  parameter  int V_SIZE   = 4,
  parameter  int H_SIZE   = 4,
  localparam int IMG_SIZE = V_SIZE * H_SIZE,
  localparam int ADDR_W   = (IMG_SIZE > 1) ? $clog2(IMG_SIZE) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              rd_pixel,
  output logic [ADDR_W-1:0] addr_pixel,
  input  logic              pixel_val,
  input  logic [PIX_W-1:0]  pixel_in,
  output logic              wr_pixel,
  output logic [PIX_W-1:0]  pixel_out,
  output logic              done
`ifdef GRAY_MEAN_EN
  ,
  output logic [PIX_W-1:0]  mean_gray
`endif
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_SIZE - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [PIX_W-1:0]  rgb_q, rgb_d;
  logic [7:0]        y_q, y_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic              done_q, done_d;

`ifdef GRAY_MEAN_EN
  localparam int SUM_W = ADDR_W + 8;

  logic [SUM_W-1:0] sum_q, sum_d;
  logic [PIX_W-1:0] mean_q, mean_d;
  logic             div_start;
  logic             div_busy;
  logic             div_done;
  logic [SUM_W-1:0] div_quot;
  logic             div_unused;

  gray_mean_div #(
    .W(SUM_W)
  ) u_div (
    .clk     (clk),
    .reset   (reset),
    .start   (div_start),
    .dividend(sum_q),
    .divisor (SUM_W'(IMG_SIZE)),
    .busy    (div_busy),
    .done    (div_done),
    .quotient(div_quot)
  );

  // The mean of 8-bit values fits in 8 bits; the upper quotient bits stay zero.
  assign div_unused = ^{div_busy, div_quot[SUM_W-1:8]};
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rgb_d   = rgb_q;
    y_d     = y_q;
`ifdef GRAY_MEAN_EN
    sum_d     = sum_q;
    mean_d    = mean_q;
    div_start = 1'b0;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          addr_d  = '0;
          state_d = ST_RD;
`ifdef GRAY_MEAN_EN
          sum_d = '0;
`endif
        end
      end
      ST_RD: state_d = ST_WAIT;
      ST_WAIT: begin
        if (pixel_val) begin
          rgb_d   = pixel_in;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        y_d     = luma(rgb_q[R_LSB +: 8], rgb_q[G_LSB +: 8], rgb_q[B_LSB +: 8]);
        state_d = ST_WR;
`ifdef GRAY_MEAN_EN
        sum_d = sum_q + SUM_W'(y_d);
`endif
      end
      ST_WR: begin
        if (addr_q == LAST_ADDR) begin
          addr_d = '0;
`ifdef GRAY_MEAN_EN
          div_start = 1'b1;
          state_d   = ST_MEAN;
`else
          state_d = ST_DONE;
`endif
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = ST_RD;
        end
      end
`ifdef GRAY_MEAN_EN
      ST_MEAN: begin
        if (div_done) begin
          mean_d  = {3{div_quot[7:0]}};
          state_d = ST_DONE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    // Strobes are registered from the next state so they align with it.
    rd_d   = (state_d == ST_RD);
    wr_d   = (state_d == ST_WR);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      rgb_q   <= '0;
      y_q     <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rgb_q   <= rgb_d;
      y_q     <= y_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      done_q  <= done_d;
    end
  end

`ifdef GRAY_MEAN_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_q  <= '0;
      mean_q <= '0;
    end else begin
      sum_q  <= sum_d;
      mean_q <= mean_d;
    end
  end

  assign mean_gray = mean_q;
`endif

  assign rd_pixel   = rd_q;
  assign wr_pixel   = wr_q;
  assign addr_pixel = addr_q;
  assign pixel_out  = {3{y_q}};
  assign done       = done_q;

endmodule
